// File: rtl/enc_position_tracker.sv
// Quadrature encoder position tracker: synchronizes the encoder and button inputs,
// accumulates quarter steps into clamped position moves, and debounces a home button.
module enc_position_tracker #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_POSITION    = 200,
    parameter int MIN_POSITION    = 0,
    parameter int POS_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_btn_n,
    output logic [POS_WIDTH-1:0] position,
    output logic                 pos_valid,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 btn_press,
    output logic                 at_max,
    output logic                 at_min,
    output logic                 enc_err
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [POS_WIDTH-1:0] POS_MAX  = POS_WIDTH'(MAX_POSITION);
    localparam logic [POS_WIDTH-1:0] POS_MIN  = POS_WIDTH'(MIN_POSITION);
    localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        MOVE_IDLE,
        MOVE_CW,
        MOVE_CCW,
        MOVE_ILLEGAL
    } move_t;

    logic [1:0]        ab_meta;
    logic [1:0]        ab_sync;
    logic [1:0]        ab_prev;
    logic              btn_meta;
    logic              btn_sync;
    logic              btn_db;
    logic [CNT_W-1:0]  db_cnt;
    logic signed [3:0] q;

    move_t             move;
    logic [1:0]        idx_prev;
    logic [1:0]        idx_cur;
    logic [1:0]        idx_diff;
    logic signed [3:0] q_step;
    logic signed [3:0] q_next;
    logic              req_up;
    logic              req_dn;
    logic              press;
    logic [POS_WIDTH-1:0] pos_next;
    logic              pv_next;
    logic              up_next;
    logic              dn_next;

    // Gray code 00,01,11,10 maps to sequence index 0..3, so CW is always +1 mod 4.
    function automatic logic [1:0] gray_to_idx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    always_comb begin
        idx_prev = gray_to_idx(ab_prev);
        idx_cur  = gray_to_idx(ab_sync);
        idx_diff = idx_cur - idx_prev;
        case (idx_diff)
            2'd1:    move = MOVE_CW;
            2'd2:    move = MOVE_ILLEGAL;
            2'd3:    move = MOVE_CCW;
            default: move = MOVE_IDLE;
        endcase

        q_step = q;
        case (move)
            MOVE_CW:      q_step = q + 4'sd1;
            MOVE_CCW:     q_step = q - 4'sd1;
            MOVE_ILLEGAL: q_step = 4'sd0;
            default:      q_step = q;
        endcase

        req_up = 1'b0;
        req_dn = 1'b0;
        q_next = q_step;
        if (q_step == 4'sd4) begin
            req_up = 1'b1;
            q_next = 4'sd0;
        end else if (q_step == -4'sd4) begin
            req_dn = 1'b1;
            q_next = 4'sd0;
        end

        press = (btn_sync != btn_db) && (db_cnt == CNT_LAST) && !btn_sync;

        // The button homes the position and overrides any coincident step.
        pos_next = position;
        pv_next  = 1'b0;
        up_next  = 1'b0;
        dn_next  = 1'b0;
        if (press) begin
            pos_next = POS_MIN;
            pv_next  = (position != POS_MIN);
            q_next   = 4'sd0;
        end else if (req_up && (position < POS_MAX)) begin
            pos_next = position + POS_ONE;
            pv_next  = 1'b1;
            up_next  = 1'b1;
        end else if (req_dn && (position > POS_MIN)) begin
            pos_next = position - POS_ONE;
            pv_next  = 1'b1;
            dn_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ab_meta   <= 2'b00;
            ab_sync   <= 2'b00;
            ab_prev   <= 2'b00;
            btn_meta  <= 1'b1;
            btn_sync  <= 1'b1;
            btn_db    <= 1'b1;
            db_cnt    <= '0;
            q         <= 4'sd0;
            position  <= POS_MIN;
            pos_valid <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            btn_press <= 1'b0;
            enc_err   <= 1'b0;
            at_max    <= 1'b0;
            at_min    <= 1'b1;
        end else begin
            ab_meta  <= {enc_a, enc_b};
            ab_sync  <= ab_meta;
            ab_prev  <= ab_sync;
            btn_meta <= enc_btn_n;
            btn_sync <= btn_meta;

            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_LAST) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_ONE;
            end

            q         <= q_next;
            position  <= pos_next;
            pos_valid <= pv_next;
            step_up   <= up_next;
            step_dn   <= dn_next;
            btn_press <= press;
            enc_err   <= (move == MOVE_ILLEGAL);
            at_max    <= (pos_next == POS_MAX);
            at_min    <= (pos_next == POS_MIN);
        end
    end
endmodule

// File: tb/tb_enc_position_tracker.sv
// Self-checking bench for enc_position_tracker: a fixed vector table, directed corner
// sequences and a randomized run compared against an arithmetic reference model.
module tb_enc_position_tracker;
    localparam int DB   = 4;
    localparam int MAXP = 5;
    localparam int MINP = 0;
    localparam int PW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enc_a;
    logic          enc_b;
    logic          enc_btn_n;
    logic [PW-1:0] position;
    logic          pos_valid;
    logic          step_up;
    logic          step_dn;
    logic          btn_press;
    logic          at_max;
    logic          at_min;
    logic          enc_err;

    enc_position_tracker #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_POSITION   (MAXP),
        .MIN_POSITION   (MINP),
        .POS_WIDTH      (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_btn_n(enc_btn_n),
        .position (position),
        .pos_valid(pos_valid),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .btn_press(btn_press),
        .at_max   (at_max),
        .at_min   (at_min),
        .enc_err  (enc_err)
    );

    always #5 clk = ~clk;

    // Flags are packed as {pos_valid, step_up, step_dn, btn_press, at_max, at_min, enc_err}.
    typedef struct {
        logic          rst;
        logic [1:0]    ab;
        logic          btn;
        logic [PW-1:0] pos;
        logic [6:0]    flags;
    } vec_t;

    vec_t vecs[17];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_up, n_dn, n_pv, n_press, n_err;

    logic [1:0] cw_order[4];
    logic [1:0] cur_ab;
    logic       btn_lvl;

    // Reference model state: plain integers plus a history of raw input samples.
    int            m_pos;
    int            m_q;
    int            m_run;
    bit            m_db;
    logic [2:0]    hist[$];
    logic [PW-1:0] e_pos;
    logic [6:0]    e_flags;

    function automatic int quarter_index(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) begin
            if (cw_order[i] == ab) return i;
        end
        return 0;
    endfunction

    function automatic logic [6:0] observed();
        return {pos_valid, step_up, step_dn, btn_press, at_max, at_min, enc_err};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_front(3'b001);
        m_pos   = MINP;
        m_q     = 0;
        m_run   = 0;
        m_db    = 1'b1;
        e_pos   = PW'(MINP);
        e_flags = 7'b0000010;
    endtask

    // A raw sample reaches the comparison two edges after capture; the one before it is "previous".
    task automatic model_edge();
        logic [2:0] cur;
        logic [2:0] prv;
        int  d;
        bit  err, up_req, dn_req, press, pv, su, sd;
        if (reset) begin
            model_reset();
            return;
        end
        hist.push_front({enc_a, enc_b, enc_btn_n});
        if (hist.size() > 4) void'(hist.pop_back());
        cur = hist[2];
        prv = hist[3];
        err = 0; up_req = 0; dn_req = 0; press = 0; pv = 0; su = 0; sd = 0;

        d = (quarter_index(cur[2:1]) - quarter_index(prv[2:1]) + 4) % 4;
        if (d == 1) m_q = m_q + 1;
        else if (d == 3) m_q = m_q - 1;
        else if (d == 2) begin
            m_q = 0;
            err = 1;
        end
        if (m_q == 4) begin
            up_req = 1;
            m_q = 0;
        end else if (m_q == -4) begin
            dn_req = 1;
            m_q = 0;
        end

        if (cur[0] != m_db) begin
            m_run = m_run + 1;
            if (m_run == DB) begin
                m_db  = cur[0];
                m_run = 0;
                press = (cur[0] == 1'b0);
            end
        end else begin
            m_run = 0;
        end

        if (press) begin
            pv    = (m_pos != MINP);
            m_pos = MINP;
            m_q   = 0;
        end else if (up_req && m_pos < MAXP) begin
            m_pos = m_pos + 1;
            pv = 1;
            su = 1;
        end else if (dn_req && m_pos > MINP) begin
            m_pos = m_pos - 1;
            pv = 1;
            sd = 1;
        end
        e_pos   = PW'(m_pos);
        e_flags = {pv, su, sd, press, (m_pos == MAXP), (m_pos == MINP), err};
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic b, input logic btn);
        reset     = r;
        enc_a     = a;
        enc_b     = b;
        enc_btn_n = btn;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        n_up    += int'(step_up);
        n_dn    += int'(step_dn);
        n_pv    += int'(pos_valid);
        n_press += int'(btn_press);
        n_err   += int'(enc_err);
    endtask

    task automatic checkOutput(input string name);
        checks++;
        if (position !== e_pos || observed() !== e_flags) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got pos=%0d flags=%b, expected pos=%0d flags=%b",
                     name, cyc, position, observed(), e_pos, e_flags);
        end
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic tick(input logic r, input logic [1:0] ab, input logic btn);
        applyStimulus(r, ab[1], ab[0], btn);
        checkOutput("model");
    endtask

    task automatic clear_counts();
        n_up = 0; n_dn = 0; n_pv = 0; n_press = 0; n_err = 0;
    endtask

    task automatic do_reset();
        cur_ab  = 2'b00;
        btn_lvl = 1'b1;
        tick(1'b1, cur_ab, btn_lvl);
        check_val("reset_position", int'(position), MINP);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, cur_ab, btn_lvl);
    endtask

    task automatic cw(input int n);
        for (int i = 0; i < n; i++) begin
            cur_ab = cw_order[(quarter_index(cur_ab) + 1) % 4];
            tick(1'b0, cur_ab, btn_lvl);
        end
    endtask

    task automatic ccw(input int n);
        for (int i = 0; i < n; i++) begin
            cur_ab = cw_order[(quarter_index(cur_ab) + 3) % 4];
            tick(1'b0, cur_ab, btn_lvl);
        end
    endtask

    initial begin
        int         r;
        logic [1:0] nab;
        logic       rst_pick;

        cw_order[0] = 2'b00;
        cw_order[1] = 2'b01;
        cw_order[2] = 2'b11;
        cw_order[3] = 2'b10;
        reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_btn_n = 1'b1;
        cur_ab = 2'b00; btn_lvl = 1'b1;
        model_reset();
        clear_counts();

        // Output after row k reflects the transition from row k-3 to row k-2 inputs.
        vecs[0]  = '{1'b1, 2'b00, 1'b1, 8'd0, 7'b0000010};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 8'd0, 7'b0000010};
        vecs[2]  = '{1'b0, 2'b11, 1'b1, 8'd0, 7'b0000010};
        vecs[3]  = '{1'b0, 2'b10, 1'b1, 8'd0, 7'b0000010};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 8'd0, 7'b0000010};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 8'd0, 7'b0000010};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 8'd1, 7'b1100000};
        vecs[7]  = '{1'b0, 2'b10, 1'b1, 8'd1, 7'b0000000};
        vecs[8]  = '{1'b0, 2'b11, 1'b1, 8'd1, 7'b0000000};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 8'd1, 7'b0000000};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 8'd1, 7'b0000000};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 8'd1, 7'b0000000};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 8'd0, 7'b1010010};
        vecs[13] = '{1'b0, 2'b11, 1'b1, 8'd0, 7'b0000010};
        vecs[14] = '{1'b0, 2'b11, 1'b1, 8'd0, 7'b0000010};
        vecs[15] = '{1'b0, 2'b11, 1'b1, 8'd0, 7'b0000011};
        vecs[16] = '{1'b0, 2'b11, 1'b1, 8'd0, 7'b0000010};

        @(negedge clk);
        $display("[TB] vector table");
        for (int k = 0; k < 17; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].ab[1], vecs[k].ab[0], vecs[k].btn);
            checks++;
            if (position !== vecs[k].pos || observed() !== vecs[k].flags) begin
                failures++;
                $display("[TB] FAIL vec%0d: got pos=%0d flags=%b, expected pos=%0d flags=%b",
                         k, position, observed(), vecs[k].pos, vecs[k].flags);
            end
        end

        $display("[TB] three CW cycles");
        do_reset();
        clear_counts();
        cw(12); idle(4);
        check_val("cw3_position", int'(position), 3);
        check_val("cw3_step_up_count", n_up, 3);
        check_val("cw3_pos_valid_count", n_pv, 3);

        $display("[TB] clamp at max");
        do_reset();
        clear_counts();
        cw(32); idle(4);
        check_val("clamp_position", int'(position), MAXP);
        check_val("clamp_at_max", int'(at_max), 1);
        check_val("clamp_step_up_count", n_up, MAXP);
        check_val("clamp_pos_valid_count", n_pv, MAXP);

        $display("[TB] illegal transition then CCW");
        do_reset();
        cw(12); idle(4);
        clear_counts();
        cur_ab = cur_ab ^ 2'b11;
        tick(1'b0, cur_ab, btn_lvl);
        idle(4);
        check_val("illegal_err_count", n_err, 1);
        check_val("illegal_position", int'(position), 3);
        ccw(4); idle(4);
        check_val("ccw_position", int'(position), 2);
        check_val("ccw_step_dn_count", n_dn, 1);

        $display("[TB] button glitch and press");
        do_reset();
        cw(16); idle(4);
        check_val("btn_start_position", int'(position), 4);
        clear_counts();
        btn_lvl = 1'b0; idle(2);
        btn_lvl = 1'b1; idle(4);
        check_val("glitch_press_count", n_press, 0);
        btn_lvl = 1'b0; idle(10);
        btn_lvl = 1'b1; idle(10);
        check_val("press_count", n_press, 1);
        check_val("press_position", int'(position), MINP);
        check_val("press_at_min", int'(at_min), 1);
        check_val("press_pos_valid_count", n_pv, 1);

        $display("[TB] reset discards partial quarters");
        do_reset();
        cw(2); idle(3);
        do_reset();
        idle(2);
        cw(2); idle(4);
        check_val("post_reset_two_quarters", int'(position), 0);
        cw(2); idle(4);
        check_val("post_reset_four_quarters", int'(position), 1);

        $display("[TB] randomized run");
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            nab = cur_ab;
            if (r < 35) nab = cw_order[(quarter_index(cur_ab) + 1) % 4];
            else if (r < 65) nab = cw_order[(quarter_index(cur_ab) + 3) % 4];
            else if (r < 68) nab = cur_ab ^ 2'b11;
            if ($urandom_range(0, 9) == 0) btn_lvl = ~btn_lvl;
            rst_pick = ($urandom_range(0, 299) == 0);
            tick(rst_pick, nab, btn_lvl);
            cur_ab = nab;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
